// File: rtl/rs_tag_allocator_pkg.sv
// ---------------------------------------------------------------------------
// rs_tag_allocator_pkg
// Shared tag definitions for the tag allocator, the map table and dispatch.
//   RSTAG_W          : tag width on every bus (8)
//   RSTAG_NULL       : "no tag" encoding (8'hFF)
//   RSTAG_READY_BIT  : map-table ready-in-ROB flag position (6)
//   RSTAG_IDX_MASK   : mask selecting the pool index bits (6'h3F)
// ---------------------------------------------------------------------------
package rs_tag_allocator_pkg;

    localparam int         RSTAG_W         = 8;
    localparam int         RSTAG_IDX_W     = 6;
    localparam int         RSTAG_READY_BIT = 6;
    localparam logic [7:0] RSTAG_NULL      = 8'hFF;
    localparam logic [5:0] RSTAG_IDX_MASK  = 6'h3F;

    // Drop the ready-in-ROB flag so a ready-marked tag indexes the pool directly.
    function automatic logic [RSTAG_W-1:0] rstag_strip_ready(input logic [RSTAG_W-1:0] tag);
        return tag & ~(8'(1) << RSTAG_READY_BIT);
    endfunction

    // Build a bus tag from a pool index; the ready flag is never set here.
    function automatic logic [RSTAG_W-1:0] rstag_from_idx(input logic [RSTAG_IDX_W-1:0] idx);
        return {2'b00, idx & RSTAG_IDX_MASK};
    endfunction

endpackage

// File: rtl/rs_tag_allocator_if.sv
// ---------------------------------------------------------------------------
// rs_tag_allocator_if
// Dispatch/retire side bundle of the tag allocator.
//   master (dispatch/retire): drives flush, inst1/2_req, free1/2_tag_in;
//                             receives grants, stalls and free count.
//   slave  (allocator)      : the reverse.
// ---------------------------------------------------------------------------
interface rs_tag_allocator_if;
    import rs_tag_allocator_pkg::*;

    logic               flush;
    logic               inst1_req;
    logic               inst2_req;
    logic [RSTAG_W-1:0] free1_tag_in;
    logic [RSTAG_W-1:0] free2_tag_in;
    logic [RSTAG_W-1:0] inst1_tag_out;
    logic [RSTAG_W-1:0] inst2_tag_out;
    logic               inst1_stall;
    logic               inst2_stall;
    logic [6:0]         free_count_out;

    modport master (
        output flush, inst1_req, inst2_req, free1_tag_in, free2_tag_in,
        input  inst1_tag_out, inst2_tag_out, inst1_stall, inst2_stall, free_count_out
    );

    modport slave (
        input  flush, inst1_req, inst2_req, free1_tag_in, free2_tag_in,
        output inst1_tag_out, inst2_tag_out, inst1_stall, inst2_stall, free_count_out
    );

endinterface

// File: rtl/rs_tag_allocator_tag_pri_enc.sv
// ---------------------------------------------------------------------------
// tag_pri_enc
// Lowest-set-bit finder.
//   vec_i   in  W      candidate vector
//   idx_o   out IDX_W  index of the lowest set bit (0 when none)
//   valid_o out 1      at least one bit of vec_i is set
// ---------------------------------------------------------------------------
module tag_pri_enc #(
    parameter int W     = 16,
    parameter int IDX_W = 6
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_tag_allocator.sv
// ---------------------------------------------------------------------------
// rs_tag_allocator
// Two-wide allocator for the RS/ROB tag pool. Slot 1 gets the lowest free tag,
// slot 2 the next lowest; tags come back through two retire/CDB free ports.
//   clock  in  system clock, posedge
//   reset  in  synchronous active-high, frees every tag
//   bus    slave side of rs_tag_allocator_if (requests, frees, flush,
//          grants, stalls, registered free count)
// ---------------------------------------------------------------------------
module rs_tag_allocator
    import rs_tag_allocator_pkg::*;
#(
    parameter int NUM_TAGS = 16
) (
    input  logic              clock,
    input  logic              reset,
    rs_tag_allocator_if.slave bus
);

    logic [NUM_TAGS-1:0]    busy_q, busy_d;
    logic [6:0]             count_q, count_d;

    logic [NUM_TAGS-1:0]    free_vec, free_vec2;
    logic [NUM_TAGS-1:0]    grant1_oh, grant2_oh, ret_oh;
    logic [RSTAG_IDX_W-1:0] idx1, idx2;
    logic                   vld1, vld2;
    logic                   grant1, grant2;
    logic [RSTAG_W-1:0]     ret1, ret2;
    logic                   ret1_ok, ret2_ok;
    logic [6:0]             freed_cnt;

    assign free_vec = ~busy_q;

    tag_pri_enc #(.W(NUM_TAGS), .IDX_W(RSTAG_IDX_W)) u_enc1 (
        .vec_i   (free_vec),
        .idx_o   (idx1),
        .valid_o (vld1)
    );

    assign grant1 = bus.inst1_req && vld1;

    always_comb begin
        grant1_oh = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            grant1_oh[i] = grant1 && (idx1 == RSTAG_IDX_W'(i));
    end

    // Removing slot 1's grant leaves slot 2 the lowest free tag above it;
    // with no slot-1 request nothing is removed and slot 2 takes the lowest.
    assign free_vec2 = free_vec & ~grant1_oh;

    tag_pri_enc #(.W(NUM_TAGS), .IDX_W(RSTAG_IDX_W)) u_enc2 (
        .vec_i   (free_vec2),
        .idx_o   (idx2),
        .valid_o (vld2)
    );

    assign grant2 = bus.inst2_req && vld2;

    always_comb begin
        grant2_oh = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            grant2_oh[i] = grant2 && (idx2 == RSTAG_IDX_W'(i));
    end

    assign bus.inst1_tag_out  = grant1 ? rstag_from_idx(idx1) : RSTAG_NULL;
    assign bus.inst2_tag_out  = grant2 ? rstag_from_idx(idx2) : RSTAG_NULL;
    assign bus.inst1_stall    = bus.inst1_req && !grant1;
    assign bus.inst2_stall    = bus.inst2_req && !grant2;
    assign bus.free_count_out = count_q;

    // Returned tags: ready flag stripped; the null code and anything beyond
    // the pool land out of range and are ignored.
    assign ret1    = rstag_strip_ready(bus.free1_tag_in);
    assign ret2    = rstag_strip_ready(bus.free2_tag_in);
    assign ret1_ok = (bus.free1_tag_in != RSTAG_NULL) && (ret1 < 8'(NUM_TAGS));
    assign ret2_ok = (bus.free2_tag_in != RSTAG_NULL) && (ret2 < 8'(NUM_TAGS));

    always_comb begin
        ret_oh = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            ret_oh[i] = (ret1_ok && ret1 == 8'(i)) || (ret2_ok && ret2 == 8'(i));
    end

    // Only busy tags count as freed, and a tag named on both ports sets a
    // single bit, so duplicates and already-free tags never inflate the count.
    always_comb begin
        freed_cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            freed_cnt = freed_cnt + 7'(ret_oh[i] & busy_q[i]);
    end

    // Granted tags are free and returned tags only matter when busy, so the
    // set and clear masks never collide on a live bit.
    assign busy_d  = (busy_q & ~ret_oh) | grant1_oh | grant2_oh;
    assign count_d = count_q - 7'(grant1) - 7'(grant2) + freed_cnt;

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            busy_q  <= '0;
            count_q <= 7'(NUM_TAGS);
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rs_tag_allocator.sv
module tb_rs_tag_allocator;

    localparam int NT = 16;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rs_tag_allocator_if bus ();

    rs_tag_allocator #(.NUM_TAGS(NT)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: one busy flag per tag.
    bit         mbusy [NT];
    int         g1, g2;
    logic [7:0] e_t1, e_t2;
    logic       e_s1, e_s2;
    logic [6:0] e_cnt;

    // Apply inputs and derive the expected outputs from the model.
    task automatic drive(input logic r1, input logic r2, input logic [7:0] f1,
                         input logic [7:0] f2, input logic fl, input logic rs);
        bus.inst1_req    = r1;
        bus.inst2_req    = r2;
        bus.free1_tag_in = f1;
        bus.free2_tag_in = f2;
        bus.flush        = fl;
        rst              = rs;
        e_cnt = 0;
        for (int i = 0; i < NT; i++) if (!mbusy[i]) e_cnt++;
        g1 = -1; g2 = -1;
        e_t1 = 8'hFF; e_t2 = 8'hFF; e_s1 = 1'b0; e_s2 = 1'b0;
        if (r1) begin
            for (int i = 0; i < NT; i++) if (!mbusy[i] && g1 < 0) g1 = i;
            if (g1 < 0) e_s1 = 1'b1; else e_t1 = 8'(g1);
        end
        if (r2) begin
            for (int i = 0; i < NT; i++) if (!mbusy[i] && i != g1 && g2 < 0) g2 = i;
            if (g2 < 0) e_s2 = 1'b1; else e_t2 = 8'(g2);
        end
        #1;
    endtask

    // Clock edge plus model update; returns on the following negedge.
    task automatic commit();
        logic [7:0] m;
        @(posedge clk);
        if (rst || bus.flush) begin
            for (int i = 0; i < NT; i++) mbusy[i] = 1'b0;
        end else begin
            m = bus.free1_tag_in & 8'hBF;
            if (m < 8'(NT)) mbusy[int'(m)] = 1'b0;
            m = bus.free2_tag_in & 8'hBF;
            if (m < 8'(NT)) mbusy[int'(m)] = 1'b0;
            if (g1 >= 0) mbusy[g1] = 1'b1;
            if (g2 >= 0) mbusy[g2] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 0, 8'hFF, 8'hFF, 0, 1);
        commit();
        drive(0, 0, 8'hFF, 8'hFF, 0, 0);
        checks++; if (bus.free_count_out !== 7'd16) begin errors++; $display("FAIL reset_count: got %0d expected 16", bus.free_count_out); end
        checks++; if (bus.inst1_tag_out !== 8'hFF) begin errors++; $display("FAIL reset_tag1: got %h expected ff", bus.inst1_tag_out); end
        checks++; if (bus.inst2_tag_out !== 8'hFF) begin errors++; $display("FAIL reset_tag2: got %h expected ff", bus.inst2_tag_out); end
        checks++; if ({bus.inst1_stall, bus.inst2_stall} !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b expected 00", {bus.inst1_stall, bus.inst2_stall}); end
        commit();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 8'hFF, 8'hFF, 0, 0);
            checks++; if (bus.inst1_tag_out !== 8'(2*k)) begin errors++; $display("FAIL b2b_tag1[%0d]: got %h expected %h", k, bus.inst1_tag_out, 8'(2*k)); end
            checks++; if (bus.inst2_tag_out !== 8'(2*k+1)) begin errors++; $display("FAIL b2b_tag2[%0d]: got %h expected %h", k, bus.inst2_tag_out, 8'(2*k+1)); end
            checks++; if (bus.free_count_out !== 7'(16-2*k)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", k, bus.free_count_out, 16-2*k); end
            checks++; if ({bus.inst1_stall, bus.inst2_stall} !== 2'b00) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected 00", k, {bus.inst1_stall, bus.inst2_stall}); end
            commit();
        end
        drive(0, 0, 8'hFF, 8'hFF, 0, 0);
        checks++; if (bus.free_count_out !== 7'd10) begin errors++; $display("FAIL b2b_count_end: got %0d expected 10", bus.free_count_out); end
        commit();
    endtask

    task automatic test_free_return();
        drive(0, 0, 8'h42, 8'h03, 0, 0);
        checks++; if (bus.free_count_out !== 7'd10) begin errors++; $display("FAIL ret_count_before: got %0d expected 10", bus.free_count_out); end
        commit();
        drive(1, 1, 8'hFF, 8'hFF, 0, 0);
        checks++; if (bus.free_count_out !== 7'd12) begin errors++; $display("FAIL ret_count_after: got %0d expected 12", bus.free_count_out); end
        checks++; if (bus.inst1_tag_out !== 8'h02) begin errors++; $display("FAIL ret_tag1: got %h expected 02", bus.inst1_tag_out); end
        checks++; if (bus.inst2_tag_out !== 8'h03) begin errors++; $display("FAIL ret_tag2: got %h expected 03", bus.inst2_tag_out); end
        commit();
    endtask

    task automatic test_last_tag();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 8'hFF, 8'hFF, 0, 0);
            checks++; if (bus.inst1_tag_out !== e_t1) begin errors++; $display("FAIL fill_tag1[%0d]: got %h expected %h", k, bus.inst1_tag_out, e_t1); end
            checks++; if (bus.inst2_tag_out !== e_t2) begin errors++; $display("FAIL fill_tag2[%0d]: got %h expected %h", k, bus.inst2_tag_out, e_t2); end
            checks++; if (bus.free_count_out !== e_cnt) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, bus.free_count_out, e_cnt); end
            commit();
        end
        drive(1, 0, 8'hFF, 8'hFF, 0, 0);
        checks++; if (bus.inst1_tag_out !== 8'h0E) begin errors++; $display("FAIL fill_single_tag1: got %h expected 0e", bus.inst1_tag_out); end
        checks++; if ({bus.inst2_tag_out, bus.inst2_stall} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL noreq_slot2: got %h/%b expected ff/0", bus.inst2_tag_out, bus.inst2_stall); end
        commit();
        drive(1, 1, 8'hFF, 8'hFF, 0, 0);
        checks++; if (bus.free_count_out !== 7'd1) begin errors++; $display("FAIL last_count: got %0d expected 1", bus.free_count_out); end
        checks++; if (bus.inst1_tag_out !== 8'h0F) begin errors++; $display("FAIL last_tag1: got %h expected 0f", bus.inst1_tag_out); end
        checks++; if ({bus.inst1_stall, bus.inst2_stall} !== 2'b01) begin errors++; $display("FAIL last_stall: got %b expected 01", {bus.inst1_stall, bus.inst2_stall}); end
        checks++; if (bus.inst2_tag_out !== 8'hFF) begin errors++; $display("FAIL last_tag2: got %h expected ff", bus.inst2_tag_out); end
        commit();
        drive(1, 1, 8'hFF, 8'hFF, 0, 0);
        checks++; if (bus.free_count_out !== 7'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", bus.free_count_out); end
        checks++; if ({bus.inst1_stall, bus.inst2_stall} !== 2'b11) begin errors++; $display("FAIL empty_stall: got %b expected 11", {bus.inst1_stall, bus.inst2_stall}); end
        checks++; if (bus.inst1_tag_out !== 8'hFF) begin errors++; $display("FAIL empty_tag1: got %h expected ff", bus.inst1_tag_out); end
        commit();
    endtask

    task automatic test_free_dup();
        drive(0, 0, 8'h05, 8'h05, 0, 0);
        commit();
        drive(0, 0, 8'hFF, 8'h20, 0, 0);
        checks++; if (bus.free_count_out !== 7'd1) begin errors++; $display("FAIL dup_free_count: got %0d expected 1", bus.free_count_out); end
        commit();
        drive(0, 0, 8'h45, 8'hFF, 0, 0);
        checks++; if (bus.free_count_out !== 7'd1) begin errors++; $display("FAIL junk_free_count: got %0d expected 1", bus.free_count_out); end
        commit();
        drive(1, 0, 8'hFF, 8'hFF, 0, 0);
        checks++; if (bus.free_count_out !== 7'd1) begin errors++; $display("FAIL refree_count: got %0d expected 1", bus.free_count_out); end
        checks++; if (bus.inst1_tag_out !== 8'h05) begin errors++; $display("FAIL refree_tag1: got %h expected 05", bus.inst1_tag_out); end
        commit();
    endtask

    task automatic test_flush(input logic use_reset);
        drive(0, 0, 8'hFF, 8'hFF, 0, 1);
        commit();
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 8'hFF, 8'hFF, 0, 0);
            commit();
        end
        drive(1, 1, 8'hFF, 8'hFF, !use_reset, use_reset);
        checks++; if (bus.free_count_out !== 7'd4) begin errors++; $display("FAIL flush%0d_count_pre: got %0d expected 4", use_reset, bus.free_count_out); end
        checks++; if ({bus.inst1_tag_out, bus.inst2_tag_out} !== 16'h0C0D) begin errors++; $display("FAIL flush%0d_grants: got %h expected 0c0d", use_reset, {bus.inst1_tag_out, bus.inst2_tag_out}); end
        commit();
        drive(1, 0, 8'hFF, 8'hFF, 0, 0);
        checks++; if (bus.free_count_out !== 7'd16) begin errors++; $display("FAIL flush%0d_count_post: got %0d expected 16", use_reset, bus.free_count_out); end
        checks++; if (bus.inst1_tag_out !== 8'h00) begin errors++; $display("FAIL flush%0d_tag1_post: got %h expected 00", use_reset, bus.inst1_tag_out); end
        commit();
    endtask

    function automatic logic [7:0] rand_free();
        case ($urandom_range(0, 9))
            0, 1, 2: return 8'hFF;
            8:       return 8'($urandom_range(16, 63));
            9:       return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(0, NT-1)) | ($urandom_range(0, 1) != 0 ? 8'h40 : 8'h00);
        endcase
    endfunction

    task automatic test_random();
        logic r1, r2, fl;
        logic [7:0] f1, f2;
        for (int n = 0; n < 400; n++) begin
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 39) == 0);
            f1 = rand_free();
            f2 = ($urandom_range(0, 7) == 0) ? f1 : rand_free();
            drive(r1, r2, f1, f2, fl, 0);
            checks++; if (bus.inst1_tag_out !== e_t1) begin errors++; $display("FAIL rand_tag1[%0d]: got %h expected %h", n, bus.inst1_tag_out, e_t1); end
            checks++; if (bus.inst2_tag_out !== e_t2) begin errors++; $display("FAIL rand_tag2[%0d]: got %h expected %h", n, bus.inst2_tag_out, e_t2); end
            checks++; if (bus.inst1_stall !== e_s1) begin errors++; $display("FAIL rand_stall1[%0d]: got %b expected %b", n, bus.inst1_stall, e_s1); end
            checks++; if (bus.inst2_stall !== e_s2) begin errors++; $display("FAIL rand_stall2[%0d]: got %b expected %b", n, bus.inst2_stall, e_s2); end
            checks++; if (bus.free_count_out !== e_cnt) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, bus.free_count_out, e_cnt); end
            commit();
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.flush        = 1'b0;
        bus.inst1_req    = 1'b0;
        bus.inst2_req    = 1'b0;
        bus.free1_tag_in = 8'hFF;
        bus.free2_tag_in = 8'hFF;
        g1 = -1;
        g2 = -1;
        for (int i = 0; i < NT; i++) mbusy[i] = 1'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_free_return();
        test_last_tag();
        test_free_dup();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_tag_allocator.md
# rs_tag_allocator

Two-wide tag allocator that owns the pool of reservation-station/ROB tags and hands a fresh tag to each dispatching instruction. It drives `inst1_tag_in`/`inst2_tag_in` of the map table and reclaims tags from two CDB/retire return ports. It is the arbiter that shares the tag pool between the two dispatch slots and tells dispatch when to stall.

## Interface
- `NUM_TAGS`, default 16: pool size; legal range 2..64. Tags `0..NUM_TAGS-1` are encoded in 8 bits. Bit 6 is never set by this block because it is the map table's ready-in-ROB bit.
- `clock`  in  1  single system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  mispredict/exception recovery; frees every tag.
- `inst1_req`  in  1  dispatch slot 1 wants a tag this cycle.
- `inst2_req`  in  1  dispatch slot 2 wants a tag this cycle.
- `free1_tag_in`  in  8  tag returned at retire; `8'hFF` means none.
- `free2_tag_in`  in  8  second returned tag; `8'hFF` means none.
- `inst1_tag_out`  out  8  tag granted to slot 1, or `8'hFF`.
- `inst2_tag_out`  out  8  tag granted to slot 2, or `8'hFF`.
- `inst1_stall`  out  1  slot 1 requested and was not granted.
- `inst2_stall`  out  1  slot 2 requested and was not granted.
- `free_count_out`  out  7  number of free tags in the current cycle.

## Operation
- State:
  - `NUM_TAGS`-bit busy vector.
  - Registered 7-bit free count, kept consistent with the vector.
- Grant order is in program order: slot 1 before slot 2.
  - Slot 1 gets the lowest-indexed free tag.
  - Slot 2 gets the lowest free tag above slot 1's grant. If slot 1 did not request, slot 2 gets the lowest free tag.
- Slot 2 is never granted while slot 1 requests and stalls. This follows from the ordering: with 0 free, both stall.
- Exactly 1 free and both request:
  - slot 1 granted;
  - `inst2_tag_out` = `8'hFF`, `inst2_stall` = 1.
- No request on a slot: that slot's tag output is `8'hFF` and its stall is 0.
- Free ports:
  - Clear the busy bit of any in-range tag.
  - Bit 6 of the incoming tag is masked off before indexing. This lets ready-marked tags be returned directly.
  - `8'hFF` and out-of-range indices are ignored.
  - Freeing an already-free tag is a no-op; the count must not change.
  - Both ports naming the same tag counts as one free.
- Next free count = current − grants + distinct tags actually freed.
- `flush`: next state is all free and count = `NUM_TAGS`. Flush overrides same-cycle grants and frees; grant outputs are still driven combinationally that cycle but are not committed.
- `reset`:
  - Same effect as flush.
  - Reset value of every output at the first negedge after reset: `free_count_out` = `NUM_TAGS`, stalls 0, tag outputs `8'hFF` while requests are low.
  - Reset mid-operation discards all allocations.

## Timing
- Grants, stalls and free count are combinational from registered state and current requests. They are valid in the same cycle as the request.
- Allocation commits at the posedge that ends the request cycle. The granted tag is busy from the next cycle.
- Freed tags become allocatable the cycle after the free. There is no same-cycle free-to-alloc bypass.
- There is no multi-cycle handshake. Dispatch holds a stalled instruction and re-requests the next cycle.
- Wrap-around: the lowest-index policy means a tag freed then re-requested is handed out again immediately. There is no rotation pointer.

## Structure
- Shared header/package holds:
  - `RSTAG_NULL` (`8'hFF`);
  - tag width 8;
  - ready-in-ROB bit position 6;
  - index mask `6'h3F`.
  The map table and dispatch use the same definitions.
- Sub-module `tag_pri_enc`: parameterised lowest-set-bit finder with index and valid outputs, instantiated twice.
  - First instance takes the free vector.
  - Second instance takes the free vector with slot 1's grant masked out.
- Everything else (busy-vector update, count arithmetic) lives in the top-level module.

## Test plan
- Reset with no requests, then hold 1 cycle -> `free_count_out` = 16, both tag outputs `8'hFF`, stalls 0.
- Both request on 3 consecutive cycles -> grants (0,1), (2,3), (4,5); `free_count_out` reads 16, 14, 12, then 10.
- Return `8'h42` and `8'h03`, no requests -> next cycle count +2. Then both request -> grants (2,3).
- Allocate until 1 tag remains (`NUM_TAGS`=16, tag 15 free), both request -> `inst1_tag_out` = `8'h0F`, `inst2_stall` = 1. Next cycle both stall, count 0.
- Same-cycle free of `8'h05` on both ports plus `8'hFF` and `8'h20` (out of range) -> count rises by exactly 1. Freeing an already-free tag leaves the count unchanged.
- Both request with `flush` = 1 while 12 tags are busy -> grants visible that cycle, next cycle count = 16 and a request gets tag 0. Repeat with `reset` in place of `flush` -> identical result.
